ase_rsp_unroller: RTL and testbench

- Transaction response generator for the ASE CCI-P simulation path.
- Accepts tagged TX requests (header plus transaction id), holds each one for a fixed minimum latency, and emits per-cache-line responses.
- Multi-line reads are unrolled into one response beat per cache line.
- Its output feeds the stream checker's valid_out/txhdr_out/rxhdr_out/tid_out inputs directly. The key it produces, {tid, clnum}, matches the key the checker stores.

---
 rtl/ase_pkg.sv | 48 ++++
 rtl/ase_sync_fifo.sv | 56 +++++
 rtl/ase_rsp_unroller.sv | 157 +++++++++++++++
 tb/tb_ase_rsp_unroller.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ase_pkg.sv
// Shared ASE CCI-P header types, request/response encodings and small decode helpers
// used by the response unroller.
package ase_pkg;

  typedef struct packed {
    logic [1:0]  vc;
    logic        sop;
    logic [1:0]  len;
    logic [3:0]  reqtype;
    logic [41:0] addr;
    logic [15:0] mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        hit_miss;
    logic        format;
    logic [1:0]  clnum;
    logic [3:0]  resptype;
    logic [15:0] mdata;
  } RxHdr_t;

  localparam logic [3:0] ASE_WRLINE_I = 4'h1;
  localparam logic [3:0] ASE_WRLINE_M = 4'h2;
  localparam logic [3:0] ASE_WRFENCE  = 4'h4;
  localparam logic [3:0] ASE_RDLINE_S = 4'h6;
  localparam logic [3:0] ASE_RDLINE_I = 4'h7;

  localparam logic [3:0] ASE_RD_RSP = 4'h0;
  localparam logic [3:0] ASE_WR_RSP = 4'h1;

  function automatic logic ase_is_read(input logic [3:0] reqtype);
    return (reqtype == ASE_RDLINE_I) || (reqtype == ASE_RDLINE_S);
  endfunction

  // Response header with only type, line number and mdata populated
  function automatic RxHdr_t ase_mk_rsp(input logic [3:0] resptype,
                                        input logic [15:0] mdata,
                                        input logic [1:0] clnum);
    RxHdr_t r;
    r          = '0;
    r.resptype = resptype;
    r.mdata    = mdata;
    r.clnum    = clnum;
    return r;
  endfunction

endpackage

// File: rtl/ase_sync_fifo.sv
// Parameterised synchronous FIFO with registered full/empty flags and occupancy count.
// Pushes while full and pops while empty are ignored.
module ase_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push, pop;

  assign push    = wr_en_i & ~full_q;
  assign pop     = rd_en_i & ~empty_q;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/ase_rsp_unroller.sv
// Holds tagged TX requests for a minimum latency, then emits one response beat per
// cache line in strict request order; write fences retire as a fence_ack pulse.
module ase_rsp_unroller import ase_pkg::*; #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LATENCY   = 8,
  parameter int unsigned TID_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  TxHdr_t               hdr_in,
  input  logic [TID_WIDTH-1:0] tid_in,
  output logic                 full,
  output logic                 overflow,
  output logic                 valid_out,
  output TxHdr_t               txhdr_out,
  output RxHdr_t               rxhdr_out,
  output logic [TID_WIDTH-1:0] tid_out,
  output logic                 fence_ack
);

  typedef struct packed {
    TxHdr_t               hdr;
    logic [TID_WIDTH-1:0] tid;
    logic [31:0]          ts;
  } rsp_entry_t;

  localparam int unsigned ENTRY_W = $bits(rsp_entry_t);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  typedef enum logic {ST_IDLE, ST_UNROLL} state_t;

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  TxHdr_t               cur_hdr_q, cur_hdr_d;
  logic [TID_WIDTH-1:0] cur_tid_q, cur_tid_d;
  logic [31:0]          ts_q;
  logic                 valid_q, valid_d, fence_q, fence_d, overflow_q;
  TxHdr_t               txhdr_q, txhdr_d;
  RxHdr_t               rxhdr_q, rxhdr_d;
  logic [TID_WIDTH-1:0] tid_q, tid_d;

  logic                 fifo_full, fifo_empty, pop_c, eligible_c;
  logic [CNT_W-1:0]     occ;
  logic [ENTRY_W-1:0]   head_bits;
  rsp_entry_t           wr_entry, head;
  logic [31:0]          age_c;

  assign wr_entry = '{hdr: hdr_in, tid: tid_in, ts: ts_q};
  assign head     = head_bits;

  ase_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (valid_in & ~fifo_full),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop_c),
    .rd_data_o (head_bits),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (occ)
  );

  // Unsigned difference keeps the age correct across timestamp wrap
  assign age_c      = ts_q - head.ts;
  assign eligible_c = ~fifo_empty & (age_c >= 32'(LATENCY));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_hdr_d = cur_hdr_q;
    cur_tid_d = cur_tid_q;
    pop_c     = 1'b0;
    valid_d   = 1'b0;
    fence_d   = 1'b0;
    txhdr_d   = txhdr_q;
    rxhdr_d   = rxhdr_q;
    tid_d     = tid_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible_c) begin
          pop_c = 1'b1;
          if (ase_is_read(head.hdr.reqtype)) begin
            valid_d = 1'b1;
            txhdr_d = head.hdr;
            tid_d   = head.tid;
            rxhdr_d = ase_mk_rsp(ASE_RD_RSP, head.hdr.mdata, 2'd0);
            if (head.hdr.len != 2'd0) begin
              cur_hdr_d = head.hdr;
              cur_tid_d = head.tid;
              cnt_d     = 2'd1;
              state_d   = ST_UNROLL;
            end
          end else if (head.hdr.reqtype == ASE_WRFENCE) begin
            fence_d = 1'b1;
          end else begin
            // Write key uses len as the line number to match the checker
            valid_d = 1'b1;
            txhdr_d = head.hdr;
            tid_d   = head.tid;
            rxhdr_d = ase_mk_rsp(ASE_WR_RSP, head.hdr.mdata, head.hdr.len);
          end
        end
      end
      ST_UNROLL: begin
        valid_d = 1'b1;
        txhdr_d = cur_hdr_q;
        tid_d   = cur_tid_q;
        rxhdr_d = ase_mk_rsp(ASE_RD_RSP, cur_hdr_q.mdata, cnt_q);
        if (cnt_q == cur_hdr_q.len) begin
          cnt_d   = 2'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_hdr_q  <= '0;
      cur_tid_q  <= '0;
      ts_q       <= '0;
      valid_q    <= 1'b0;
      fence_q    <= 1'b0;
      overflow_q <= 1'b0;
      txhdr_q    <= '0;
      rxhdr_q    <= '0;
      tid_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_hdr_q  <= cur_hdr_d;
      cur_tid_q  <= cur_tid_d;
      ts_q       <= ts_q + 32'd1;
      valid_q    <= valid_d;
      fence_q    <= fence_d;
      overflow_q <= overflow_q | (valid_in & (occ == CNT_W'(DEPTH)));
      txhdr_q    <= txhdr_d;
      rxhdr_q    <= rxhdr_d;
      tid_q      <= tid_d;
    end
  end

  assign full      = fifo_full;
  assign overflow  = overflow_q;
  assign valid_out = valid_q;
  assign fence_ack = fence_q;
  assign txhdr_out = txhdr_q;
  assign rxhdr_out = rxhdr_q;
  assign tid_out   = tid_q;

endmodule

// File: tb/tb_ase_rsp_unroller.sv
// Randomised self-checking bench for ase_rsp_unroller against a transaction-level
// schedule model (per-request issue slot, beat list and occupancy by pop time).
module tb_ase_rsp_unroller;
  import ase_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 8;
  localparam int unsigned LAT2  = 32;
  localparam int unsigned TW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  TxHdr_t        hdr_in = '0;
  logic [TW-1:0] tid_in = '0;

  logic full, overflow, valid_out, fence_ack;
  TxHdr_t txhdr_out; RxHdr_t rxhdr_out; logic [TW-1:0] tid_out;
  logic o2_full, o2_overflow, o2_valid, o2_fence;
  TxHdr_t o2_txhdr; RxHdr_t o2_rxhdr; logic [TW-1:0] o2_tid;

  always #5 clk = ~clk;

  ase_rsp_unroller #(.DEPTH(DEPTH), .LATENCY(LAT), .TID_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .hdr_in(hdr_in), .tid_in(tid_in),
    .full(full), .overflow(overflow), .valid_out(valid_out), .txhdr_out(txhdr_out),
    .rxhdr_out(rxhdr_out), .tid_out(tid_out), .fence_ack(fence_ack));

  // Long-latency instance so back-to-back pushes can fill the FIFO
  ase_rsp_unroller #(.DEPTH(DEPTH), .LATENCY(LAT2), .TID_WIDTH(TW)) u_ovf (
    .clk(clk), .rst(rst), .valid_in(valid_in), .hdr_in(hdr_in), .tid_in(tid_in),
    .full(o2_full), .overflow(o2_overflow), .valid_out(o2_valid), .txhdr_out(o2_txhdr),
    .rxhdr_out(o2_rxhdr), .tid_out(o2_tid), .fence_ack(o2_fence));

  typedef struct {int cyc; bit fence; TxHdr_t tx; RxHdr_t rx; logic [TW-1:0] tid;} ev_t;
  typedef struct {bit v; bit f; bit full; bit ovf; TxHdr_t tx; RxHdr_t rx; logic [TW-1:0] tid;} exp_t;

  ev_t ev_q[$];
  int  pop_q[$];
  int  cyc, next_slot, m_lat;
  bit  m_ovf;
  int  n_chk = 0, n_fail = 0;

  function automatic TxHdr_t mk_hdr(input logic [3:0] rt, input logic [1:0] len);
    TxHdr_t h;
    h.vc = 2'($urandom); h.sop = 1'($urandom); h.len = len; h.reqtype = rt;
    h.addr = 42'({$urandom, $urandom}); h.mdata = 16'($urandom);
    return h;
  endfunction

  function automatic TxHdr_t rand_hdr();
    logic [3:0] rt;
    case ($urandom_range(4))
      0: rt = ASE_RDLINE_I;
      1: rt = ASE_RDLINE_S;
      2: rt = ASE_WRLINE_I;
      3: rt = ASE_WRLINE_M;
      default: rt = ASE_WRFENCE;
    endcase
    return mk_hdr(rt, 2'($urandom));
  endfunction

  // Schedule a request: issue no earlier than enqueue+latency+1, nor before the previous one ends
  task automatic model_enq(input TxHdr_t h, input logic [TW-1:0] t);
    int first, nb;
    ev_t ev;
    if (pop_q.size() >= DEPTH) begin m_ovf = 1'b1; return; end
    first = (cyc + m_lat + 1 > next_slot) ? cyc + m_lat + 1 : next_slot;
    pop_q.push_back(first - 1);
    ev.tx = h; ev.tid = t; ev.rx = '0; ev.rx.mdata = h.mdata; ev.fence = 1'b0;
    if (h.reqtype == ASE_WRFENCE) begin
      ev.cyc = first; ev.fence = 1'b1; ev.rx = '0; ev_q.push_back(ev); nb = 1;
    end else if (h.reqtype == ASE_RDLINE_I || h.reqtype == ASE_RDLINE_S) begin
      nb = int'(h.len) + 1;
      for (int i = 0; i < nb; i++) begin
        ev.cyc = first + i; ev.rx.resptype = ASE_RD_RSP; ev.rx.clnum = 2'(i); ev_q.push_back(ev);
      end
    end else begin
      ev.cyc = first; ev.rx.resptype = ASE_WR_RSP; ev.rx.clnum = h.len; ev_q.push_back(ev); nb = 1;
    end
    next_slot = first + nb;
  endtask

  task automatic model_expect(output exp_t e);
    ev_t ev;
    e.v = 1'b0; e.f = 1'b0; e.tx = '0; e.rx = '0; e.tid = '0;
    e.full = (pop_q.size() == DEPTH); e.ovf = m_ovf;
    if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
      ev = ev_q.pop_front();
      e.v = !ev.fence; e.f = ev.fence; e.tx = ev.tx; e.rx = ev.rx; e.tid = ev.tid;
    end
  endtask

  task automatic step(input bit v, input TxHdr_t h, input logic [TW-1:0] t);
    valid_in = v; hdr_in = h; tid_in = t;
    if (v) model_enq(h, t);
    @(posedge clk); #1;
    cyc++;
    valid_in = 1'b0;
    while (pop_q.size() > 0 && pop_q[0] < cyc) void'(pop_q.pop_front());
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ev_q.delete(); pop_q.delete();
    cyc = 0; next_slot = 0; m_ovf = 1'b0; m_lat = lat;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; hdr_in = mk_hdr(ASE_RDLINE_I, 2'd1);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({valid_out, fence_ack, full, overflow, txhdr_out, rxhdr_out, tid_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b f=%b full=%b ovf=%b tid=%h exp all zero",
               valid_out, fence_ack, full, overflow, tid_out);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_single_read();
    exp_t e; int first_seen = -1;
    do_reset(LAT);
    for (int c = 0; c < 24; c++) begin
      step(c == 5, mk_hdr(ASE_RDLINE_I, 2'd3), 32'h10);
      model_expect(e);
      n_chk++;
      if ({valid_out, fence_ack, full, overflow} !== {e.v, e.f, e.full, e.ovf}) begin
        n_fail++; $display("FAIL rd4_ctl cyc=%0d got=%b exp=%b", cyc,
                           {valid_out, fence_ack, full, overflow}, {e.v, e.f, e.full, e.ovf});
      end
      if (e.v) begin
        n_chk++;
        if ({txhdr_out, rxhdr_out, tid_out} !== {e.tx, e.rx, e.tid}) begin
          n_fail++; $display("FAIL rd4_beat cyc=%0d got rx=%h tid=%h exp rx=%h tid=%h",
                             cyc, rxhdr_out, tid_out, e.rx, e.tid);
        end
      end
      if (valid_out && first_seen < 0) first_seen = cyc;
    end
    n_chk++;
    if (first_seen != 14) begin
      n_fail++; $display("FAIL rd4_first_cycle got=%0d exp=14", first_seen);
    end
  endtask

  task automatic test_write();
    exp_t e; int beats = 0;
    do_reset(LAT);
    for (int c = 0; c < 16; c++) begin
      step(c == 0, mk_hdr(ASE_WRLINE_I, 2'd1), 32'h22);
      model_expect(e);
      n_chk++;
      if ({valid_out, fence_ack, full, overflow} !== {e.v, e.f, e.full, e.ovf}) begin
        n_fail++; $display("FAIL wr_ctl cyc=%0d got=%b exp=%b", cyc,
                           {valid_out, fence_ack, full, overflow}, {e.v, e.f, e.full, e.ovf});
      end
      if (e.v) begin
        n_chk++;
        if ({txhdr_out, rxhdr_out, tid_out} !== {e.tx, e.rx, e.tid}) begin
          n_fail++; $display("FAIL wr_beat cyc=%0d got rx=%h tid=%h exp rx=%h tid=%h",
                             cyc, rxhdr_out, tid_out, e.rx, e.tid);
        end
      end
      if (valid_out) beats++;
    end
    n_chk++;
    if (beats != 1) begin n_fail++; $display("FAIL wr_beat_count got=%0d exp=1", beats); end
  endtask

  task automatic test_fence();
    exp_t e; int beats = 0, fences = 0;
    TxHdr_t h;
    do_reset(LAT);
    for (int c = 0; c < 18; c++) begin
      h = (c == 1) ? mk_hdr(ASE_WRFENCE, 2'd0) : mk_hdr(ASE_RDLINE_S, 2'd0);
      step(c < 3, h, 32'(32'hA0 + c));
      model_expect(e);
      n_chk++;
      if ({valid_out, fence_ack, full, overflow} !== {e.v, e.f, e.full, e.ovf}) begin
        n_fail++; $display("FAIL fence_ctl cyc=%0d got=%b exp=%b", cyc,
                           {valid_out, fence_ack, full, overflow}, {e.v, e.f, e.full, e.ovf});
      end
      if (e.v) begin
        n_chk++;
        if ({txhdr_out, rxhdr_out, tid_out} !== {e.tx, e.rx, e.tid}) begin
          n_fail++; $display("FAIL fence_beat cyc=%0d got tid=%h exp tid=%h", cyc, tid_out, e.tid);
        end
      end
      if (valid_out) beats++;
      if (fence_ack) fences++;
    end
    n_chk++;
    if (beats != 2 || fences != 1) begin
      n_fail++; $display("FAIL fence_counts got beats=%0d fences=%0d exp beats=2 fences=1", beats, fences);
    end
  endtask

  task automatic test_overflow();
    exp_t e; int done = 0;
    do_reset(LAT2);
    for (int c = 0; c < 120; c++) begin
      step(c < 17, rand_hdr(), 32'(c));
      model_expect(e);
      n_chk++;
      if ({o2_valid, o2_fence, o2_full, o2_overflow} !== {e.v, e.f, e.full, e.ovf}) begin
        n_fail++; $display("FAIL ovf_ctl cyc=%0d got=%b exp=%b", cyc,
                           {o2_valid, o2_fence, o2_full, o2_overflow}, {e.v, e.f, e.full, e.ovf});
      end
      if (e.v) begin
        n_chk++;
        if ({o2_txhdr, o2_rxhdr, o2_tid} !== {e.tx, e.rx, e.tid}) begin
          n_fail++; $display("FAIL ovf_beat cyc=%0d got rx=%h tid=%h exp rx=%h tid=%h",
                             cyc, o2_rxhdr, o2_tid, e.rx, e.tid);
        end
      end
      if (cyc == 16) begin
        n_chk++;
        if (o2_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_after_16 got=%b exp=1", o2_full); end
      end
      if (o2_fence) done++;
      if (o2_valid && (o2_rxhdr.resptype == ASE_WR_RSP || o2_rxhdr.clnum == o2_txhdr.len)) done++;
    end
    n_chk++;
    if (o2_overflow !== 1'b1 || done != 16) begin
      n_fail++; $display("FAIL ovf_summary got ovf=%b txns=%0d exp ovf=1 txns=16", o2_overflow, done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int run = 0, best = 0, nbeat = 0;
    logic [TW-1:0] tid5 = '0;
    do_reset(LAT);
    for (int c = 0; c < 22; c++) begin
      step(c < 2, mk_hdr(ASE_RDLINE_I, 2'd3), 32'(c + 1));
      model_expect(e);
      n_chk++;
      if ({valid_out, fence_ack, full, overflow} !== {e.v, e.f, e.full, e.ovf}) begin
        n_fail++; $display("FAIL b2b_ctl cyc=%0d got=%b exp=%b", cyc,
                           {valid_out, fence_ack, full, overflow}, {e.v, e.f, e.full, e.ovf});
      end
      if (e.v) begin
        n_chk++;
        if ({txhdr_out, rxhdr_out, tid_out} !== {e.tx, e.rx, e.tid}) begin
          n_fail++; $display("FAIL b2b_beat cyc=%0d got rx=%h tid=%h exp rx=%h tid=%h",
                             cyc, rxhdr_out, tid_out, e.rx, e.tid);
        end
      end
      if (valid_out) begin
        run++; nbeat++;
        if (nbeat == 5) tid5 = tid_out;
      end else run = 0;
      if (run > best) best = run;
    end
    n_chk++;
    if (best != 8 || tid5 !== 32'd2) begin
      n_fail++; $display("FAIL b2b_run got run=%0d tid5=%0d exp run=8 tid5=2", best, tid5);
    end
  endtask

  task automatic test_reset_mid_unroll();
    exp_t e;
    do_reset(LAT);
    for (int c = 0; c < 10; c++) begin
      step(c == 0, mk_hdr(ASE_RDLINE_I, 2'd3), 32'h33);
      model_expect(e);
      n_chk++;
      if ({valid_out, fence_ack, txhdr_out.len, rxhdr_out.clnum} !== {e.v, e.f, e.tx.len, e.rx.clnum}) begin
        n_fail++; $display("FAIL rstmid_pre cyc=%0d got v=%b clnum=%0d exp v=%b clnum=%0d",
                           cyc, valid_out, rxhdr_out.clnum, e.v, e.rx.clnum);
      end
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({valid_out, fence_ack, full, overflow, txhdr_out, rxhdr_out, tid_out} !== '0) begin
      n_fail++; $display("FAIL rstmid_zero got v=%b tid=%h clnum=%0d exp all zero",
                         valid_out, tid_out, rxhdr_out.clnum);
    end
    do_reset(LAT);
    for (int c = 0; c < 20; c++) begin
      step(c == 4, mk_hdr(ASE_RDLINE_I, 2'd0), 32'h44);
      model_expect(e);
      n_chk++;
      if ({valid_out, fence_ack, full, overflow} !== {e.v, e.f, e.full, e.ovf}) begin
        n_fail++; $display("FAIL rstmid_post_ctl cyc=%0d got=%b exp=%b", cyc,
                           {valid_out, fence_ack, full, overflow}, {e.v, e.f, e.full, e.ovf});
      end
      if (e.v) begin
        n_chk++;
        if ({txhdr_out, rxhdr_out, tid_out} !== {e.tx, e.rx, e.tid}) begin
          n_fail++; $display("FAIL rstmid_post_beat cyc=%0d got tid=%h exp tid=%h", cyc, tid_out, e.tid);
        end
      end
    end
  endtask

  task automatic test_ts_wrap();
    exp_t e; int first_seen = -1;
    do_reset(LAT);
    force dut.ts_q = 32'hFFFF_FFF8;
    step(1'b0, '0, '0);
    release dut.ts_q;
    for (int c = 0; c < 40; c++) begin
      step((c == 2) || (c > 6 && $urandom_range(99) < 40), rand_hdr(), $urandom);
      model_expect(e);
      n_chk++;
      if ({valid_out, fence_ack, full, overflow} !== {e.v, e.f, e.full, e.ovf}) begin
        n_fail++; $display("FAIL wrap_ctl cyc=%0d got=%b exp=%b", cyc,
                           {valid_out, fence_ack, full, overflow}, {e.v, e.f, e.full, e.ovf});
      end
      if (e.v) begin
        n_chk++;
        if ({txhdr_out, rxhdr_out, tid_out} !== {e.tx, e.rx, e.tid}) begin
          n_fail++; $display("FAIL wrap_beat cyc=%0d got tid=%h exp tid=%h", cyc, tid_out, e.tid);
        end
      end
      if ((valid_out || fence_ack) && first_seen < 0) first_seen = cyc;
    end
    n_chk++;
    if (first_seen != 3 + int'(LAT) + 1) begin
      n_fail++; $display("FAIL wrap_latency got first=%0d exp=%0d", first_seen, 3 + LAT + 1);
    end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset(LAT);
    for (int c = 0; c < 400; c++) begin
      step((c < 360) && ($urandom_range(99) < 45), rand_hdr(), $urandom);
      model_expect(e);
      n_chk++;
      if ({valid_out, fence_ack, full, overflow} !== {e.v, e.f, e.full, e.ovf}) begin
        n_fail++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", cyc,
                           {valid_out, fence_ack, full, overflow}, {e.v, e.f, e.full, e.ovf});
      end
      if (e.v) begin
        n_chk++;
        if ({txhdr_out, rxhdr_out, tid_out} !== {e.tx, e.rx, e.tid}) begin
          n_fail++; $display("FAIL rand_beat cyc=%0d got rx=%h tid=%h exp rx=%h tid=%h",
                             cyc, rxhdr_out, tid_out, e.rx, e.tid);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_fence();
    test_overflow();
    test_back_to_back();
    test_reset_mid_unroll();
    test_ts_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d exp completion before time limit", cyc);
    $fatal(1);
  end

endmodule
